// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states and
// redirect kinds. Redirect codes are ordered by priority so a plain
// magnitude compare picks the winner.
package fetch_ctrl_pkg;

  localparam int FETCH_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_FETCH   = 2'd1,
    ST_WAIT_ID = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_EXC  = 2'd2,
    RD_DBG  = 2'd3
  } redir_e;

  // Exception and debug redirects throw away in-flight and buffered words.
  function automatic logic is_flush(input redir_e k);
    return (k == RD_EXC) || (k == RD_DBG);
  endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_latch.sv
// Pending-redirect register. Holds at most one redirect; a newer request of
// higher priority replaces it, anything lower or equal is dropped. The
// output is the effective redirect for this cycle (pending merged with the
// live request), so a request can be applied in the cycle it arrives.
module redirect_latch
  import fetch_ctrl_pkg::*;
#(
  parameter int W = FETCH_ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         br_req_i,
  input  logic [W-1:0] br_target_i,
  input  logic         exc_req_i,
  input  logic [W-1:0] exc_pc_i,
  input  logic         dbg_req_i,
  input  logic [W-1:0] dbg_pc_i,
  input  logic         clear_i,
  output logic [1:0]   kind_o,
  output logic [W-1:0] target_o
);

  redir_e         kind_q, kind_d, req_kind;
  logic [W-1:0]   tgt_q, tgt_d, req_tgt;

  // Pick the live request by priority, then merge it with the pending entry.
  always_comb begin
    req_kind = RD_NONE;
    req_tgt  = '0;
    if (dbg_req_i) begin
      req_kind = RD_DBG;
      req_tgt  = dbg_pc_i;
    end else if (exc_req_i) begin
      req_kind = RD_EXC;
      req_tgt  = exc_pc_i;
    end else if (br_req_i) begin
      req_kind = RD_BR;
      req_tgt  = br_target_i;
    end
    kind_d = kind_q;
    tgt_d  = tgt_q;
    if (req_kind > kind_q) begin
      kind_d = req_kind;
      tgt_d  = req_tgt;
    end
  end

  // Capture the merged redirect until the fetch boundary consumes it.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      kind_q <= RD_NONE;
      tgt_q  <= '0;
    end else begin
      kind_q <= kind_d;
      tgt_q  <= tgt_d;
    end
  end

  assign kind_o   = kind_d;
  assign target_o = tgt_d;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: issues bus requests at pc_reg, hands words to ID
// through a registered buffer plus one skid entry, and decides when and
// where the pc unit advances.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RESET   | one cycle after reset; bus idle, stray acks ignored
// ST_FETCH   | request outstanding at pc_reg, waiting for ibus_ack
// ST_WAIT_ID | fetched word parked in skid, ID stalled with buffer full
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_reg,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_ack,
  input  logic [ADDR_W-1:0] ibus_rdata,
  input  logic              id_stall,
  input  logic              br_req,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_pc,
  output logic              pc_enable,
  output logic              pc_is_branch,
  output logic              pc_is_exception,
  output logic              pc_is_debug,
  output logic [ADDR_W-1:0] pc_target,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  state_e            state_q;
  logic              inst_valid_q;
  logic [ADDR_W-1:0] inst_q, inst_pc_q;
  logic [ADDR_W-1:0] skid_inst_q, skid_pc_q;

  logic [1:0]        eff_kind_raw;
  redir_e            eff_kind, apply_kind;
  logic [ADDR_W-1:0] eff_target;
  logic              flush_eff, flush_req, buf_free;

  redirect_latch #(.W(ADDR_W)) u_redir (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_req_i   (br_req),
    .br_target_i(br_target),
    .exc_req_i  (exc_req),
    .exc_pc_i   (exc_pc),
    .dbg_req_i  (dbg_req),
    .dbg_pc_i   (dbg_pc),
    .clear_i    (pc_enable),
    .kind_o     (eff_kind_raw),
    .target_o   (eff_target)
  );

  assign eff_kind  = redir_e'(eff_kind_raw);
  assign flush_eff = is_flush(eff_kind);
  assign flush_req = exc_req || dbg_req;
  assign buf_free  = !inst_valid_q || !id_stall;

  // Gated by rst_n so an asserted reset drops the request at once.
  assign ibus_req  = rst_n && (state_q == ST_FETCH);
  assign ibus_addr = ibus_req ? pc_reg : '0;

  // pc advance decode; combinational so pc_reg moves on the edge after the ack.
  always_comb begin
    pc_enable = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_FETCH:   pc_enable = ibus_ack && (flush_eff || buf_free);
        ST_WAIT_ID: pc_enable = flush_eff || !id_stall;
        default:    pc_enable = 1'b0;
      endcase
    end
    apply_kind      = pc_enable ? eff_kind : RD_NONE;
    pc_is_branch    = (apply_kind == RD_BR);
    pc_is_exception = (apply_kind == RD_EXC);
    pc_is_debug     = (apply_kind == RD_DBG);
    pc_target       = (apply_kind != RD_NONE) ? eff_target : '0;
  end

  // FSM with the output buffer and skid entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      if (!id_stall) inst_valid_q <= 1'b0;
      case (state_q)
        ST_RESET: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (ibus_ack && !flush_eff) begin
            if (buf_free) begin
              inst_valid_q <= 1'b1;
              inst_q       <= ibus_rdata;
              inst_pc_q    <= pc_reg;
            end else begin
              skid_inst_q <= ibus_rdata;
              skid_pc_q   <= pc_reg;
              state_q     <= ST_WAIT_ID;
            end
          end
        end
        ST_WAIT_ID: begin
          if (flush_eff) begin
            state_q <= ST_FETCH;
          end else if (!id_stall) begin
            inst_valid_q <= 1'b1;
            inst_q       <= skid_inst_q;
            inst_pc_q    <= skid_pc_q;
            state_q      <= ST_FETCH;
          end
        end
        default: state_q <= ST_RESET;
      endcase
      // Leaving WAIT_ID above already drops the skid on a flush.
      if (flush_req) inst_valid_q <= 1'b0;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule
